riscv_lsu_sb: RTL

//  Parametrised load/store unit between the RISC-V execute stage and the data bus.

---
 rtl/riscv_lsu_sb.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_lsu_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : riscv_lsu_sb                                                    |
// | Brief    : RISC-V load/store unit with posted store buffer and optional    |
// |            two-beat handling of word-crossing accesses.                    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module riscv_lsu_sb #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int SB_DEPTH       = 4,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_re,
    input  logic                  i_we,
    input  logic [2:0]            i_funct3,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_bus_stall,
    output logic                  o_fault,
    output logic                  o_sb_empty,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [ADDR_W-1:0]     o_bus_addr,
    output logic [DATA_W/8-1:0]   o_bus_be,
    output logic [DATA_W-1:0]     o_bus_wdata,
    input  logic                  i_bus_gnt,
    input  logic                  i_bus_rvalid,
    input  logic [DATA_W-1:0]     i_bus_rdata
);

    localparam int BW    = DATA_W / 8;
    localparam int OFF_W = $clog2(BW);
    localparam int PTR_W = $clog2(SB_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ1  = 3'd1;
    localparam logic [2:0] S_WAIT1 = 3'd2;
    localparam logic [2:0] S_REQ2  = 3'd3;
    localparam logic [2:0] S_WAIT2 = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // ---------------- request decode ----------------
    logic [3:0]          w_size;
    logic                w_sext;
    logic                w_legal;
    always_comb begin
        w_size  = 4'd1;
        w_sext  = 1'b0;
        w_legal = 1'b1;
        case (i_funct3)
            3'b000: begin w_size = 4'd1; w_sext = 1'b1; end
            3'b001: begin w_size = 4'd2; w_sext = 1'b1; end
            3'b010: begin w_size = 4'd4; w_sext = 1'b1; end
            3'b011: begin w_size = 4'd8; w_legal = (DATA_W == 64); end
            3'b100: begin w_size = 4'd1; end
            3'b101: begin w_size = 4'd2; end
            3'b110: begin w_size = 4'd4; w_legal = (DATA_W == 64); end
            default: begin w_legal = 1'b0; end
        endcase
    end

    logic [OFF_W-1:0]    w_off;
    logic [4:0]          w_end;
    logic                w_cross;
    logic [ADDR_W-1:0]   w_addr0;
    logic [ADDR_W-1:0]   w_addr1;
    assign w_off   = i_addr[OFF_W-1:0];
    assign w_end   = 5'(w_off) + 5'(w_size);
    // Only an access that spills past the word needs a second beat.
    assign w_cross = (w_end > 5'(BW));
    assign w_addr0 = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_addr1 = w_addr0 + ADDR_W'(BW);

    logic [DATA_W-1:0]   w_wmask;
    always_comb begin
        w_wmask = '0;
        for (int b = 0; b < BW; b++) begin
            w_wmask[b*8 +: 8] = (4'(b) < w_size) ? 8'hFF : 8'h00;
        end
    end

    logic [2*BW-1:0]     w_be_cat;
    logic [2*DATA_W-1:0] w_wd_cat;
    assign w_be_cat = (((2*BW)'(1) << w_size) - (2*BW)'(1)) << w_off;
    assign w_wd_cat = (2*DATA_W)'(i_wdata & w_wmask) << {w_off, 3'b000};

    logic                w_bad;
    logic                w_ld;
    logic                w_st;
    logic [1:0]          w_need;
    assign w_bad   = (i_re & i_we) | ~w_legal | (w_cross & (MISALIGN_SPLIT == 0));
    assign o_fault = (i_re | i_we) & w_bad;
    assign w_ld    = i_re & ~i_we & ~w_bad;
    assign w_st    = i_we & ~i_re & ~w_bad;
    assign w_need  = w_cross ? 2'd2 : 2'd1;

    // ---------------- store buffer ----------------
    logic [ADDR_W-1:0]   r_sb_addr [SB_DEPTH];
    logic [BW-1:0]       r_sb_be   [SB_DEPTH];
    logic [DATA_W-1:0]   r_sb_data [SB_DEPTH];
    logic [PTR_W:0]      r_wptr;
    logic [PTR_W:0]      r_rptr;
    logic [PTR_W:0]      w_count;
    logic                w_empty;
    logic [PTR_W-1:0]    w_head;
    assign w_count    = r_wptr - r_rptr;
    assign w_empty    = (w_count == '0);
    assign o_sb_empty = w_empty;
    assign w_head     = r_rptr[PTR_W-1:0];

    logic                w_hazard;
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (((PTR_W+1)'(PTR_W'(i) - w_head) < w_count) &&
                ((r_sb_addr[i] == w_addr0) || (w_cross && (r_sb_addr[i] == w_addr1)))) begin
                w_hazard = 1'b1;
            end
        end
    end

    logic [2:0]          r_state;
    logic                r_drain_held;
    logic                w_load_go;
    logic                w_drain_req;
    logic                w_pop;
    logic [PTR_W+1:0]    w_free;
    logic                w_space;
    logic                w_push;

    // A drain beat already presented without grant must finish before a load takes the bus.
    assign w_load_go   = (r_state == S_IDLE) & w_ld & ~w_hazard & ~r_drain_held;
    assign w_drain_req = ~w_empty & ((r_state == S_IDLE) | (r_state == S_DONE)) & ~w_load_go;
    assign w_pop       = w_drain_req & i_bus_gnt;
    assign w_free      = (PTR_W+2)'(SB_DEPTH) - (PTR_W+2)'(w_count) + (PTR_W+2)'(w_pop);
    assign w_space     = (w_free >= (PTR_W+2)'(w_need));
    assign w_push      = w_st & w_space;
    assign o_bus_stall = (w_ld & (r_state != S_DONE)) | (w_st & ~w_space);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sb_addr[r_wptr[PTR_W-1:0]] <= w_addr0;
            r_sb_be  [r_wptr[PTR_W-1:0]] <= w_be_cat[BW-1:0];
            r_sb_data[r_wptr[PTR_W-1:0]] <= w_wd_cat[DATA_W-1:0];
            if (w_cross) begin
                r_sb_addr[r_wptr[PTR_W-1:0] + PTR_W'(1)] <= w_addr1;
                r_sb_be  [r_wptr[PTR_W-1:0] + PTR_W'(1)] <= w_be_cat[2*BW-1:BW];
                r_sb_data[r_wptr[PTR_W-1:0] + PTR_W'(1)] <= w_wd_cat[2*DATA_W-1:DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_drain_held <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (PTR_W+1)'(w_need);
            if (w_pop)  r_rptr <= r_rptr + (PTR_W+1)'(1);
            r_drain_held <= w_drain_req & ~i_bus_gnt;
        end
    end

    // ---------------- load FSM ----------------
    logic [ADDR_W-1:0]   r_ld_addr0;
    logic [ADDR_W-1:0]   r_ld_addr1;
    logic [BW-1:0]       r_ld_be0;
    logic [BW-1:0]       r_ld_be1;
    logic [OFF_W-1:0]    r_ld_off;
    logic [3:0]          r_ld_size;
    logic                r_ld_sext;
    logic                r_ld_split;
    logic [DATA_W-1:0]   r_beat0;
    logic [DATA_W-1:0]   r_rdata;

    logic [DATA_W-1:0]   w_lo;
    logic [DATA_W-1:0]   w_hi;
    logic [2*DATA_W-1:0] w_cat;
    logic [DATA_W-1:0]   w_sh;
    logic [6:0]          w_nbits;
    logic [DATA_W-1:0]   w_mask;
    logic [DATA_W-1:0]   w_topbit;
    logic                w_sign;
    logic [DATA_W-1:0]   w_result;
    logic                w_last;

    // The final beat is merged straight off the bus so the result is ready in DONE.
    assign w_lo     = (r_state == S_WAIT1) ? i_bus_rdata : r_beat0;
    assign w_hi     = (r_state == S_WAIT2) ? i_bus_rdata : '0;
    assign w_cat    = {w_hi, w_lo};
    assign w_sh     = DATA_W'(w_cat >> {r_ld_off, 3'b000});
    assign w_nbits  = {r_ld_size, 3'b000};
    assign w_mask   = {DATA_W{1'b1}} >> (7'(DATA_W) - w_nbits);
    assign w_topbit = DATA_W'(1) << (w_nbits - 7'd1);
    assign w_sign   = |(w_sh & w_topbit);
    assign w_result = (w_sh & w_mask) | ((r_ld_sext & w_sign) ? ~w_mask : '0);
    assign w_last   = i_bus_rvalid &
                      (((r_state == S_WAIT1) & ~r_ld_split) | (r_state == S_WAIT2));
    assign o_rdata  = r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ld_addr0 <= '0;
            r_ld_addr1 <= '0;
            r_ld_be0   <= '0;
            r_ld_be1   <= '0;
            r_ld_off   <= '0;
            r_ld_size  <= '0;
            r_ld_sext  <= 1'b0;
            r_ld_split <= 1'b0;
            r_beat0    <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_last) r_rdata <= w_result;
            case (r_state)
                S_IDLE: begin
                    if (w_load_go) begin
                        r_state    <= S_REQ1;
                        r_ld_addr0 <= w_addr0;
                        r_ld_addr1 <= w_addr1;
                        r_ld_be0   <= w_be_cat[BW-1:0];
                        r_ld_be1   <= w_be_cat[2*BW-1:BW];
                        r_ld_off   <= w_off;
                        r_ld_size  <= w_size;
                        r_ld_sext  <= w_sext;
                        r_ld_split <= w_cross;
                    end
                end
                S_REQ1:  if (i_bus_gnt) r_state <= S_WAIT1;
                S_WAIT1: begin
                    if (i_bus_rvalid) begin
                        r_beat0 <= i_bus_rdata;
                        r_state <= r_ld_split ? S_REQ2 : S_DONE;
                    end
                end
                S_REQ2:  if (i_bus_gnt) r_state <= S_WAIT2;
                S_WAIT2: if (i_bus_rvalid) r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- bus mux ----------------
    always_comb begin
        o_bus_req   = 1'b0;
        o_bus_we    = 1'b0;
        o_bus_addr  = '0;
        o_bus_be    = '0;
        o_bus_wdata = '0;
        if (r_state == S_REQ1) begin
            o_bus_req  = 1'b1;
            o_bus_addr = r_ld_addr0;
            o_bus_be   = r_ld_be0;
        end else if (r_state == S_REQ2) begin
            o_bus_req  = 1'b1;
            o_bus_addr = r_ld_addr1;
            o_bus_be   = r_ld_be1;
        end else if (w_drain_req) begin
            o_bus_req   = 1'b1;
            o_bus_we    = 1'b1;
            o_bus_addr  = r_sb_addr[w_head];
            o_bus_be    = r_sb_be[w_head];
            o_bus_wdata = r_sb_data[w_head];
        end
    end

endmodule
`default_nettype wire
